// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory port arbiter.
package dmem_arb_pkg;

    localparam int DATA_W_DEF = 18;
    localparam int ADDR_W_DEF = 18;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CPU_ACC    = 2'd1,
        DISP_BURST = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_CPU  = 1'b0,
        GNT_DISP = 1'b1
    } gnt_t;

endpackage

// File: rtl/dmem_burst_agen.sv
// Display burst address generator: latches the base at grant, counts beats,
// produces base+beat (wrapping at 2^ADDR_W) and flags the final beat.
module dmem_burst_agen #(
    parameter int ADDR_W    = 18,
    parameter int BURST_LEN = 8,
    parameter int CNT_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              advance,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] beat_addr,
    output logic              last
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  cnt;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base <= '0;
            cnt  <= '0;
        end else if (start) begin
            base <= start_addr;
            cnt  <= (BURST_LEN == 1) ? '0 : CNT_W'(1);
        end else if (advance) begin
            cnt  <= last ? '0 : cnt + CNT_W'(1);
        end
    end

    // Beat 0 issues in the grant cycle straight from the requester's address.
    assign beat_addr = start ? start_addr : base + ADDR_W'(cnt);
    assign last      = start ? (BURST_LEN == 1) : (cnt == LAST_CNT);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous data RAM between the CPU MEM
// stage and the display burst engine. Optional stall counter: ARB_STALL_CNT_EN.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int BURST_LEN = 8,
    parameter int CNT_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    output logic              disp_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       stall_cnt
);

    arb_state_t        state, state_nxt;
    gnt_t              last_gnt;
    logic              in_burst, port_free, cpu_pick;
    logic              cpu_gnt, disp_gnt, disp_issue;
    logic              cpu_load_q;
    logic [ADDR_W-1:0] beat_addr;
    logic              beat_last;
    logic [DATA_W-1:0] cpu_hold, disp_hold;

    // Grants are held off during reset so cpu_stall simply mirrors cpu_req.
    assign in_burst   = (state == DISP_BURST);
    assign port_free  = rst & ~in_burst;
    assign cpu_pick   = cpu_req & (~disp_req | (last_gnt == GNT_DISP));
    assign cpu_gnt    = port_free & cpu_pick;
    assign disp_gnt   = port_free & disp_req & ~cpu_pick;
    assign disp_issue = disp_gnt | in_burst;
    assign cpu_stall  = cpu_req & ~cpu_gnt;

    dmem_burst_agen #(
        .ADDR_W    (ADDR_W),
        .BURST_LEN (BURST_LEN),
        .CNT_W     (CNT_W)
    ) u_agen (
        .clk        (clk),
        .rst        (rst),
        .start      (disp_gnt),
        .advance    (in_burst),
        .start_addr (disp_addr),
        .beat_addr  (beat_addr),
        .last       (beat_last)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        state_nxt = IDLE;
        if (cpu_gnt) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            state_nxt = CPU_ACC;
        end else if (disp_issue) begin
            mem_en    = 1'b1;
            mem_addr  = beat_addr;
            state_nxt = beat_last ? IDLE : DISP_BURST;
        end
    end

    // NOTE: the read-data hold registers are reset too, so outputs read 0 after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last_gnt    <= GNT_DISP;
            cpu_load_q  <= 1'b0;
            disp_rvalid <= 1'b0;
            disp_done   <= 1'b0;
            cpu_hold    <= '0;
            disp_hold   <= '0;
        end else begin
            state       <= state_nxt;
            disp_rvalid <= disp_issue;
            disp_done   <= disp_issue & beat_last;
            if (cpu_gnt) begin
                last_gnt   <= GNT_CPU;
                cpu_load_q <= ~cpu_we;
            end else if (disp_gnt) begin
                last_gnt   <= GNT_DISP;
            end
            if (cpu_rvalid)  cpu_hold  <= mem_rdata;
            if (disp_rvalid) disp_hold <= mem_rdata;
        end
    end

    // RAM data arrives in the cycle after issue; pass it through, else hold.
    assign cpu_rvalid = (state == CPU_ACC) & cpu_load_q;
    assign cpu_rdata  = cpu_rvalid  ? mem_rdata : cpu_hold;
    assign disp_rdata = disp_rvalid ? mem_rdata : disp_hold;

`ifdef ARB_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= 16'd0;
        else if (cpu_stall && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomised + directed bench for dmem_port_arbiter against a transaction-level
// model (round-robin grant, burst beat queue, shadow memory).
module tb_dmem_port_arbiter;

    localparam int DW = 18;
    localparam int AW = 18;
    localparam int BL = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, disp_req;
    logic [AW-1:0] cpu_addr, disp_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall, cpu_rvalid, disp_rvalid, disp_done;
    logic [DW-1:0] cpu_rdata, disp_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [15:0]   stall_cnt;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_rdata(disp_rdata),
        .disp_rvalid(disp_rvalid), .disp_done(disp_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
    );

    // RAM seen by the DUT, plus an independent shadow the model reads from.
    logic [DW-1:0] ram [logic [AW-1:0]];
    logic [DW-1:0] sh  [logic [AW-1:0]];

    function automatic logic [DW-1:0] init_word(logic [AW-1:0] a);
        return (a * 18'd37) ^ 18'h15A5A;
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] = mem_wdata;
            else        mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : init_word(mem_addr);
        end
    end

    function automatic logic [DW-1:0] sh_rd(logic [AW-1:0] a);
        return sh.exists(a) ? sh[a] : init_word(a);
    endfunction

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (cycle %0d): got %h, required %h", name, cyc, act, exp);
        end
    endtask

    // Model state: who was granted last, beats still to issue, expected returns.
    bit            m_last_disp;
    int            m_left;
    logic [AW-1:0] m_baddr;
    bit            e_crv, e_drv, e_done;
    logic [DW-1:0] e_crd, e_drd;
    int unsigned   m_scnt;
    bit            g_cg, g_dg, g_issue;
    logic [AW-1:0] g_iaddr;

    task automatic model_reset();
        m_last_disp = 1'b1;
        m_left      = 0;
        m_baddr     = '0;
        e_crv = 0; e_drv = 0; e_done = 0;
        e_crd = '0; e_drd = '0;
        m_scnt = 0;
    endtask

    task automatic step(input bit cr, input bit cw, input logic [AW-1:0] ca,
                        input logic [DW-1:0] cd, input bit dr, input logic [AW-1:0] da);
        bit            cg, dg, issue, last;
        logic [AW-1:0] ia;
        logic [31:0]   exp_scnt;
        @(negedge clk);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        disp_req = dr; disp_addr = da;
        #1;
        cyc++;
        cg = 0; dg = 0; issue = 0; last = 0; ia = '0;
        if (m_left > 0) begin
            issue   = 1;
            ia      = m_baddr;
            m_left  = m_left - 1;
            last    = (m_left == 0);
            m_baddr = m_baddr + 18'd1;
        end else if (cr && (!dr || m_last_disp)) begin
            cg = 1;
        end else if (dr) begin
            dg      = 1;
            issue   = 1;
            ia      = da;
            m_left  = BL - 1;
            m_baddr = da + 18'd1;
            last    = (BL == 1);
        end
`ifdef ARB_STALL_CNT_EN
        exp_scnt = m_scnt;
`else
        exp_scnt = 0;
`endif
        check("mem_en", mem_en, cg | issue);
        if (cg | issue) begin
            check("mem_we",   mem_we,   cg & cw);
            check("mem_addr", mem_addr, cg ? ca : ia);
            if (cg) check("mem_wdata", mem_wdata, cd);
        end
        check("cpu_stall",   cpu_stall,   cr & ~cg);
        check("cpu_rvalid",  cpu_rvalid,  e_crv);
        check("cpu_rdata",   cpu_rdata,   e_crd);
        check("disp_rvalid", disp_rvalid, e_drv);
        check("disp_done",   disp_done,   e_done);
        check("disp_rdata",  disp_rdata,  e_drd);
        check("stall_cnt",   stall_cnt,   exp_scnt);
        // Effects of this cycle's clock edge.
        e_crv = cg & ~cw;
        if (cg & ~cw) e_crd = sh_rd(ca);
        if (cg & cw)  sh[ca] = cd;
        if (cg) m_last_disp = 0;
        if (dg) m_last_disp = 1;
        e_drv  = issue;
        if (issue) e_drd = sh_rd(ia);
        e_done = issue & last;
        if ((cr & ~cg) && m_scnt != 32'hFFFF) m_scnt++;
        g_cg = cg; g_dg = dg; g_issue = issue; g_iaddr = ia;
    endtask

    task automatic idle();
        step(0, 0, '0, '0, 0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        cpu_req = 0; disp_req = 0;
        #1 rst = 0;
        model_reset();
        @(negedge clk);
        #1 rst = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            nrv, ndone, stalls, gnt_seen;
        logic [AW-1:0] exp5 [BL];
        bit            cr, cw, dr;
        logic [AW-1:0] ca, da;
        logic [DW-1:0] cd;

        rst = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        disp_req = 0; disp_addr = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst mem_en",      mem_en,      0);
        check("rst cpu_rvalid",  cpu_rvalid,  0);
        check("rst disp_rvalid", disp_rvalid, 0);
        check("rst disp_done",   disp_done,   0);
        check("rst cpu_rdata",   cpu_rdata,   0);
        check("rst disp_rdata",  disp_rdata,  0);
        check("rst stall_cnt",   stall_cnt,   0);
        cpu_req = 1;
        #1;
        check("rst stall follows req", cpu_stall, 1);
        check("rst no grant",          mem_en,    0);
        cpu_req = 0;
        @(negedge clk);
        #1 rst = 1;

        // Store then load back-to-back.
        step(1, 1, 18'h00010, 18'h3FFFF, 0, '0);
        check("t1 store stall", cpu_stall, 0);
        check("t1 store we",    mem_we,    1);
        step(1, 0, 18'h00010, '0, 0, '0);
        check("t1 load stall", cpu_stall, 0);
        idle();
        check("t1 rvalid", cpu_rvalid, 1);
        check("t1 rdata",  cpu_rdata,  18'h3FFFF);
        idle();
        check("t1 rvalid drop", cpu_rvalid, 0);
        check("t1 rdata hold",  cpu_rdata,  18'h3FFFF);

        // Plain burst from 0x100.
        nrv = 0; ndone = 0;
        step(0, 0, '0, '0, 1, 18'h00100);
        check("t2 beat0 addr", mem_addr, 18'h00100);
        for (int i = 1; i < BL; i++) begin
            idle();
            check("t2 beat addr", mem_addr, 18'h00100 + 18'(i));
            check("t2 beat we",   mem_we,   0);
            nrv += disp_rvalid;
            ndone += disp_done;
        end
        idle();
        nrv += disp_rvalid;
        check("t2 done on last", disp_done, 1);
        ndone += disp_done;
        idle();
        check("t2 rvalid count", nrv,   BL);
        check("t2 done count",   ndone, 1);

        // Simultaneous requests after reset: CPU, then DISP, then the CPU waits.
        do_reset();
        step(1, 0, 18'h00020, '0, 1, 18'h00180);
        check("t3 cpu first", mem_addr, 18'h00020);
        check("t3 model cpu", g_cg, 1);
        step(1, 1, 18'h00021, 18'h01234, 1, 18'h00180);
        check("t3 disp second", mem_addr, 18'h00180);
        stalls = 1; gnt_seen = 0;
        for (int i = 0; i < 20 && !gnt_seen; i++) begin
            step(1, 1, 18'h00021, 18'h01234, 0, '0);
            if (cpu_stall) stalls++;
            else gnt_seen = 1;
        end
        check("t3 cpu granted", gnt_seen, 1);
        check("t3 stall cycles", stalls, BL);
        idle(); idle();

        // CPU arriving at beat 2 waits for the remaining six beats.
        step(0, 0, '0, '0, 1, 18'h00140);
        idle();
        stalls = 0; gnt_seen = 0;
        for (int i = 0; i < 20 && !gnt_seen; i++) begin
            step(1, 0, 18'h00141, '0, 0, '0);
            if (cpu_stall) stalls++;
            else gnt_seen = 1;
        end
        check("t4 cpu granted", gnt_seen, 1);
        check("t4 stall cycles", stalls, 6);
        check("t4 grant addr", mem_addr, 18'h00141);
        idle(); idle();

        // Address wrap at the top of memory.
        exp5[0] = 18'h3FFFE; exp5[1] = 18'h3FFFF;
        for (int i = 2; i < BL; i++) exp5[i] = 18'(i - 2);
        step(0, 0, '0, '0, 1, 18'h3FFFE);
        check("t5 addr", mem_addr, exp5[0]);
        for (int i = 1; i < BL; i++) begin
            idle();
            check("t5 addr", mem_addr, exp5[i]);
            check("t5 model addr", g_iaddr, exp5[i]);
        end
        idle(); idle();

        // Reset at beat 4 aborts the burst; a fresh request starts at beat 0.
        step(0, 0, '0, '0, 1, 18'h00200);
        for (int i = 1; i < 4; i++) idle();
        @(negedge clk);
        cpu_req = 0; disp_req = 0;
        #1 rst = 0;
        #1;
        check("t6 mem_en",      mem_en,      0);
        check("t6 disp_rvalid", disp_rvalid, 0);
        check("t6 disp_done",   disp_done,   0);
        check("t6 disp_rdata",  disp_rdata,  0);
        check("t6 cpu_rdata",   cpu_rdata,   0);
        check("t6 stall_cnt",   stall_cnt,   0);
        model_reset();
        @(negedge clk);
        #1;
        check("t6 held no done", disp_done, 0);
        rst = 1;
        step(0, 0, '0, '0, 1, 18'h00300);
        check("t6 restart beat0", mem_addr, 18'h00300);
        for (int i = 1; i < BL; i++) idle();
        idle();
        check("t6 done", disp_done, 1);
        idle();

        // Random traffic; requests are held until the model says granted.
        cr = 0; cw = 0; ca = '0; cd = '0; dr = 0; da = '0;
        for (int n = 0; n < 2000; n++) begin
            if (!cr || g_cg) begin
                cr = ($urandom % 3) == 0;
                cw = $urandom % 2;
                ca = ($urandom % 4 == 0) ? 18'h3FFF0 + 18'($urandom % 16) : 18'($urandom % 64);
                cd = 18'($urandom);
            end
            if (!dr || g_dg || m_left > 0) begin
                dr = ($urandom % 6) == 0;
                da = ($urandom % 3 == 0) ? 18'h3FFF8 + 18'($urandom % 8) : 18'($urandom % 64);
            end
            step(cr, cw, ca, cd, dr, da);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
